// File: rtl/pipeline_stall_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_stall_ctrl
//
// Stall and hazard controller for an in-order pipeline. Each memory request
// channel has a small FSM that tracks an outstanding access. While any port
// is waiting, the whole pipeline is frozen. A load-use hazard without a
// memory stall holds PC and IF/ID and injects a bubble into ID/EX. A
// saturating counter records how many cycles were lost to either cause.
//
// Ports
//   clk            : clock, all state updates on the rising edge
//   reset          : synchronous, active-high reset
//   mem_req        : per-port memory access requested this cycle (level)
//   mem_complete   : per-port access done (one-cycle pulse)
//   id_ex_mem_read : ID/EX instruction is a load
//   id_ex_rd       : destination register of the ID/EX instruction
//   if_id_rs       : rs source register of the IF/ID instruction
//   if_id_rt       : rt source register of the IF/ID instruction
//   if_id_uses_rt  : IF/ID instruction reads rt
//   pc_write       : PC update enable
//   stage_write    : pipeline-register write enables (bit 0 = IF/ID)
//   insert_bubble  : zero the control fields entering ID/EX
//   port_busy      : port currently stalling the pipeline
//   stall_count    : cycles with any stall since reset (saturating)
// ---------------------------------------------------------------------------
module pipeline_stall_ctrl #(
    parameter int NUM_PORTS  = 2,
    parameter int NUM_STAGES = 4,
    parameter int REG_BITS   = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_PORTS-1:0]  mem_req,
    input  logic [NUM_PORTS-1:0]  mem_complete,
    input  logic                  id_ex_mem_read,
    input  logic [REG_BITS-1:0]   id_ex_rd,
    input  logic [REG_BITS-1:0]   if_id_rs,
    input  logic [REG_BITS-1:0]   if_id_rt,
    input  logic                  if_id_uses_rt,
    output logic                  pc_write,
    output logic [NUM_STAGES-1:0] stage_write,
    output logic                  insert_bubble,
    output logic [NUM_PORTS-1:0]  port_busy,
    output logic [CNT_W-1:0]      stall_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } port_state_e;

    port_state_e           state_q [NUM_PORTS];
    port_state_e           state_d [NUM_PORTS];
    logic [NUM_PORTS-1:0]  busy_raw;
    logic                  mem_stall;
    logic                  load_use;
    logic [CNT_W-1:0]      stall_count_q;

    // A port stalls from the very cycle its request appears, so the IDLE
    // term makes the freeze zero-latency.
    always_comb begin
        busy_raw = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            busy_raw[i] = ((state_q[i] == IDLE) && mem_req[i]) || (state_q[i] == WAIT);
        end
    end

    assign mem_stall = |busy_raw;

    // Register 0 is hard-wired zero and never creates a dependency.
    assign load_use = id_ex_mem_read && (id_ex_rd != '0) &&
                      ((id_ex_rd == if_id_rs) || (if_id_uses_rt && (id_ex_rd == if_id_rt)));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                state_q[i] <= IDLE;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                state_q[i] <= state_d[i];
            end
        end
    end

    // Next-state logic. A DONE port waits for the global freeze to lift so
    // that all finished ports release together on the same edge.
    always_comb begin
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                IDLE: begin
                    if (mem_req[i]) begin
                        state_d[i] = mem_complete[i] ? DONE : WAIT;
                    end
                end
                WAIT: begin
                    // A withdrawn request aborts the wait even if a late
                    // completion arrives in the same cycle.
                    if (!mem_req[i]) begin
                        state_d[i] = IDLE;
                    end else if (mem_complete[i]) begin
                        state_d[i] = DONE;
                    end
                end
                DONE: begin
                    if (!mem_stall) begin
                        state_d[i] = IDLE;
                    end
                end
                default: state_d[i] = IDLE;
            endcase
        end
    end

    // Output logic: reset forces the all-run pattern, then memory freeze
    // outranks the load-use bubble.
    always_comb begin
        pc_write      = 1'b1;
        stage_write   = '1;
        insert_bubble = 1'b0;
        port_busy     = '0;
        if (!reset) begin
            port_busy = busy_raw;
            if (mem_stall) begin
                pc_write    = 1'b0;
                stage_write = '0;
            end else if (load_use) begin
                pc_write       = 1'b0;
                stage_write    = '1;
                stage_write[0] = 1'b0;
                insert_bubble  = 1'b1;
            end
        end
    end

    // Saturating stall-cycle counter
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count_q <= '0;
        end else if ((mem_stall || load_use) && (stall_count_q != '1)) begin
            stall_count_q <= stall_count_q + CNT_W'(1);
        end
    end

    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_stall_ctrl
//
// Self-checking bench for pipeline_stall_ctrl. Each scenario task drives a
// per-cycle stimulus table, pushes the expected output vector onto a
// scoreboard queue, and pops/compares it on the falling edge. A second
// instance with a 4-bit counter exercises saturation.
// ---------------------------------------------------------------------------
module tb_pipeline_stall_ctrl;

    localparam int K_RUN = 0;  // pc_write=1, stage_write=1111, no bubble
    localparam int K_FRZ = 1;  // full freeze
    localparam int K_BUB = 2;  // load-use bubble

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [1:0]  mem_req;
    logic [1:0]  mem_complete;
    logic        id_ex_mem_read;
    logic [4:0]  id_ex_rd;
    logic [4:0]  if_id_rs;
    logic [4:0]  if_id_rt;
    logic        if_id_uses_rt;
    logic        pc_write;
    logic [3:0]  stage_write;
    logic        insert_bubble;
    logic [1:0]  port_busy;
    logic [15:0] stall_count;

    logic        s_reset;
    logic [1:0]  s_req;
    logic [1:0]  s_cmp;
    logic        s_mr;
    logic [4:0]  s_rd;
    logic [4:0]  s_rs;
    logic [4:0]  s_rt;
    logic        s_urt;
    logic        s_pc;
    logic [3:0]  s_sw;
    logic        s_bub;
    logic [1:0]  s_busy;
    logic [3:0]  s_cnt;

    pipeline_stall_ctrl #(
        .NUM_PORTS (2),
        .NUM_STAGES(4),
        .REG_BITS  (5),
        .CNT_W     (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .mem_req       (mem_req),
        .mem_complete  (mem_complete),
        .id_ex_mem_read(id_ex_mem_read),
        .id_ex_rd      (id_ex_rd),
        .if_id_rs      (if_id_rs),
        .if_id_rt      (if_id_rt),
        .if_id_uses_rt (if_id_uses_rt),
        .pc_write      (pc_write),
        .stage_write   (stage_write),
        .insert_bubble (insert_bubble),
        .port_busy     (port_busy),
        .stall_count   (stall_count)
    );

    pipeline_stall_ctrl #(
        .CNT_W(4)
    ) u_sat (
        .clk           (clk),
        .reset         (s_reset),
        .mem_req       (s_req),
        .mem_complete  (s_cmp),
        .id_ex_mem_read(s_mr),
        .id_ex_rd      (s_rd),
        .if_id_rs      (s_rs),
        .if_id_rt      (s_rt),
        .if_id_uses_rt (s_urt),
        .pc_write      (s_pc),
        .stage_write   (s_sw),
        .insert_bubble (s_bub),
        .port_busy     (s_busy),
        .stall_count   (s_cnt)
    );

    typedef struct packed {
        logic        pc;
        logic [3:0]  sw;
        logic        bub;
        logic [1:0]  busy;
        logic [15:0] cnt;
    } obs_t;

    obs_t        sb[$];
    logic [3:0]  sat_sb[$];
    logic [15:0] exp_cnt;
    int          checks;
    int          errors;

    function automatic string fmt(input obs_t o);
        return $sformatf("pc_write=%b stage_write=%b bubble=%b port_busy=%b stall_count=%0d",
                         o.pc, o.sw, o.bub, o.busy, o.cnt);
    endfunction

    task automatic drive(input logic rst, input logic [1:0] req, input logic [1:0] cmp,
                         input logic mr, input logic [4:0] rd, input logic [4:0] rs,
                         input logic [4:0] rt, input logic urt);
        reset          = rst;
        mem_req        = req;
        mem_complete   = cmp;
        id_ex_mem_read = mr;
        id_ex_rd       = rd;
        if_id_rs       = rs;
        if_id_rt       = rt;
        if_id_uses_rt  = urt;
    endtask

    // Expected counter value is the one visible this cycle; it then steps
    // according to whether this cycle is a stall cycle.
    task automatic push_exp(input logic rst, input int kind, input logic [1:0] busy);
        obs_t e;
        e.pc   = (kind == K_RUN);
        e.sw   = (kind == K_RUN) ? 4'b1111 : (kind == K_BUB) ? 4'b1110 : 4'b0000;
        e.bub  = (kind == K_BUB);
        e.busy = busy;
        e.cnt  = exp_cnt;
        sb.push_back(e);
        if (rst) exp_cnt = '0;
        else if (kind != K_RUN) exp_cnt = exp_cnt + 16'd1;
    endtask

    task automatic test_reset();
        obs_t got, e;
        for (int c = 0; c < 4; c++) begin
            if (c < 3) begin
                drive(1'b1, 2'b11, 2'b01, 1'b1, 5'd3, 5'd3, 5'd0, 1'b0);
                push_exp(1'b1, K_RUN, 2'b00);
            end else begin
                drive(1'b0, 2'b00, 2'b00, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
                push_exp(1'b0, K_RUN, 2'b00);
            end
            @(negedge clk);
            got = {pc_write, stage_write, insert_bubble, port_busy, stall_count};
            e = sb.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL reset c%0d: got %s, expected %s", c, fmt(got), fmt(e));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_port1_single();
        logic [1:0] req_t  [7] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00};
        logic [1:0] cmp_t  [7] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00};
        int         kind_t [7] = '{K_FRZ, K_FRZ, K_FRZ, K_FRZ, K_FRZ, K_RUN, K_RUN};
        logic [1:0] busy_t [7] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00};
        obs_t got, e;
        for (int c = 0; c < 7; c++) begin
            drive(1'b0, req_t[c], cmp_t[c], 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
            push_exp(1'b0, kind_t[c], busy_t[c]);
            @(negedge clk);
            got = {pc_write, stage_write, insert_bubble, port_busy, stall_count};
            e = sb.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL port1_single c%0d: got %s, expected %s", c, fmt(got), fmt(e));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_two_ports();
        logic [1:0] cmp_t  [10] = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00};
        logic [1:0] busy_t [10] = '{2'b11, 2'b11, 2'b11, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00};
        obs_t got, e;
        for (int c = 0; c < 10; c++) begin
            drive(1'b0, (c < 9) ? 2'b11 : 2'b00, cmp_t[c], 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
            push_exp(1'b0, (c < 8) ? K_FRZ : K_RUN, busy_t[c]);
            @(negedge clk);
            got = {pc_write, stage_write, insert_bubble, port_busy, stall_count};
            e = sb.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL two_ports c%0d: got %s, expected %s", c, fmt(got), fmt(e));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_use();
        logic       mr_t   [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [4:0] rd_t   [6] = '{5'd3, 5'd3, 5'd0, 5'd7, 5'd7, 5'd0};
        logic [4:0] rs_t   [6] = '{5'd3, 5'd3, 5'd0, 5'd1, 5'd1, 5'd0};
        logic [4:0] rt_t   [6] = '{5'd0, 5'd0, 5'd0, 5'd7, 5'd7, 5'd0};
        logic       urt_t  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        int         kind_t [6] = '{K_BUB, K_RUN, K_RUN, K_BUB, K_RUN, K_RUN};
        obs_t got, e;
        for (int c = 0; c < 6; c++) begin
            drive(1'b0, 2'b00, 2'b00, mr_t[c], rd_t[c], rs_t[c], rt_t[c], urt_t[c]);
            push_exp(1'b0, kind_t[c], 2'b00);
            @(negedge clk);
            got = {pc_write, stage_write, insert_bubble, port_busy, stall_count};
            e = sb.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL load_use c%0d: got %s, expected %s", c, fmt(got), fmt(e));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_use_with_mem();
        logic [1:0] cmp_t  [5] = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00};
        int         kind_t [5] = '{K_FRZ, K_FRZ, K_FRZ, K_BUB, K_RUN};
        logic [1:0] busy_t [5] = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b00};
        obs_t got, e;
        for (int c = 0; c < 5; c++) begin
            if (c < 4) drive(1'b0, 2'b01, cmp_t[c], 1'b1, 5'd3, 5'd3, 5'd0, 1'b0);
            else       drive(1'b0, 2'b00, 2'b00, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
            push_exp(1'b0, kind_t[c], busy_t[c]);
            @(negedge clk);
            got = {pc_write, stage_write, insert_bubble, port_busy, stall_count};
            e = sb.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL lu_with_mem c%0d: got %s, expected %s", c, fmt(got), fmt(e));
            end
            @(posedge clk); #1;
        end
    endtask

    // Completion without request is ignored; dropping a request in WAIT aborts it.
    task automatic test_idle_and_abort();
        logic [1:0] req_t  [7] = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b00, 2'b00};
        logic [1:0] cmp_t  [7] = '{2'b11, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
        int         kind_t [7] = '{K_RUN, K_FRZ, K_FRZ, K_RUN, K_FRZ, K_FRZ, K_RUN};
        logic [1:0] busy_t [7] = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00};
        obs_t got, e;
        for (int c = 0; c < 7; c++) begin
            drive(1'b0, req_t[c], cmp_t[c], 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
            push_exp(1'b0, kind_t[c], busy_t[c]);
            @(negedge clk);
            got = {pc_write, stage_write, insert_bubble, port_busy, stall_count};
            e = sb.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL idle_abort c%0d: got %s, expected %s", c, fmt(got), fmt(e));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_wait();
        logic       rst_t  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [1:0] req_t  [8] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00};
        logic [1:0] cmp_t  [8] = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00};
        int         kind_t [8] = '{K_FRZ, K_FRZ, K_FRZ, K_RUN, K_RUN, K_FRZ, K_RUN, K_RUN};
        logic [1:0] busy_t [8] = '{2'b10, 2'b10, 2'b10, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00};
        obs_t got, e;
        for (int c = 0; c < 8; c++) begin
            drive(rst_t[c], req_t[c], cmp_t[c], 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
            push_exp(rst_t[c], kind_t[c], busy_t[c]);
            @(negedge clk);
            got = {pc_write, stage_write, insert_bubble, port_busy, stall_count};
            e = sb.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL reset_mid_wait c%0d: got %s, expected %s", c, fmt(got), fmt(e));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_saturation();
        logic [3:0] got, e;
        s_reset = 1'b1;
        @(posedge clk); #1;
        s_reset = 1'b0;
        s_req   = 2'b01;
        for (int c = 0; c < 22; c++) begin
            sat_sb.push_back((c > 15) ? 4'd15 : 4'(c));
            @(negedge clk);
            got = s_cnt;
            e = sat_sb.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL saturation c%0d: stall_count=%0d expected %0d", c, got, e);
            end
            @(posedge clk); #1;
        end
        s_req = 2'b00;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        exp_cnt = '0;
        s_reset = 1'b1;
        s_req   = '0;
        s_cmp   = '0;
        s_mr    = 1'b0;
        s_rd    = '0;
        s_rs    = '0;
        s_rt    = '0;
        s_urt   = 1'b0;
        drive(1'b1, 2'b00, 2'b00, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        @(posedge clk); #1;
        test_reset();
        test_port1_single();
        test_two_ports();
        test_load_use();
        test_load_use_with_mem();
        test_idle_and_abort();
        test_reset_mid_wait();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pipeline_stall_ctrl.md
PIPELINE_STALL_CTRL -- requirements
Module: pipeline_stall_ctrl

Interface
REQ-001 Parameter NUM_PORTS, default 2, is the number of memory request channels (port 0 = I-side, port 1 = D-side; range 1..8).
REQ-002 Parameter NUM_STAGES, default 4, is the number of pipeline-register write enables (bit 0 = IF/ID ... bit NUM_STAGES-1 = MEM/WB).
REQ-003 Parameter REG_BITS, default 5, is the register-specifier width.
REQ-004 Parameter CNT_W, default 16, is the stall-counter width.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 mem_req  input  NUM_PORTS  per-port memory access requested by the pipeline this cycle (level).
REQ-008 mem_complete  input  NUM_PORTS  per-port memory access done (one-cycle pulse from cache/memory).
REQ-009 id_ex_mem_read  input  1  instruction in ID/EX is a load.
REQ-010 id_ex_rd  input  REG_BITS  destination register of the ID/EX instruction.
REQ-011 if_id_rs, if_id_rt  input  REG_BITS each  source registers of the IF/ID instruction.
REQ-012 if_id_uses_rt  input  1  IF/ID instruction reads rt.
REQ-013 pc_write  output  1  PC update enable.
REQ-014 stage_write  output  NUM_STAGES  pipeline-register write enables.
REQ-015 insert_bubble  output  1  zero the control fields entering ID/EX.
REQ-016 port_busy  output  NUM_PORTS  port currently stalling the pipeline.
REQ-017 stall_count  output  CNT_W  cycles with any stall since reset.

Function
REQ-018 Each port SHALL have a registered FSM with states IDLE, WAIT, DONE.
REQ-019 IDLE: mem_req=1 and mem_complete=0 -> WAIT; mem_req=1 and mem_complete=1 -> DONE; otherwise stay; mem_complete without mem_req is ignored.
REQ-020 WAIT: mem_complete=1 -> DONE, else stay; mem_req dropping in WAIT -> IDLE.
REQ-021 DONE: hold until a cycle with mem_stall=0, then -> IDLE at that edge; a DONE port does not stall even with mem_req still high.
REQ-022 port_busy[i] SHALL be combinational: (IDLE and mem_req[i]) or WAIT.
REQ-023 mem_stall = OR of port_busy; asserted in the same cycle the request first appears (zero latency).
REQ-024 load_use = id_ex_mem_read and id_ex_rd != 0 and (id_ex_rd == if_id_rs or (if_id_uses_rt and id_ex_rd == if_id_rt)).
REQ-025 Priority 1, mem_stall: pc_write=0, stage_write=all 0, insert_bubble=0 (full freeze).
REQ-026 Priority 2, load_use without mem_stall: pc_write=0, stage_write[0]=0, stage_write[NUM_STAGES-1:1]=all 1, insert_bubble=1, for exactly one cycle per hazard occurrence.
REQ-027 Otherwise: pc_write=1, stage_write=all 1, insert_bubble=0.
REQ-028 Multiple ports busy: freeze holds until every port is IDLE or DONE; all DONE ports return to IDLE on the same release edge.
REQ-029 stall_count SHALL increment by 1 each cycle mem_stall or load_use is true, saturating at 2^CNT_W-1 (no wrap).
REQ-030 All outputs except stall_count SHALL be combinational from FSM state and inputs; no output glitch-free requirement beyond single-clock-domain use.

Reset
REQ-031 On a rising edge with reset=1, all port FSMs -> IDLE and stall_count -> 0, aborting any WAIT/DONE; mem_complete that cycle is discarded.
REQ-032 While reset=1, outputs SHALL be pc_write=1, stage_write=all 1, insert_bubble=0, port_busy=0 regardless of other inputs.

Verification
REQ-033 Port 1 mem_req=1 at cycle 10, mem_complete pulse at cycle 14 -> stage_write=0000, port_busy=10 in cycles 10-14; cycle 15 all-run; stall_count=5.
REQ-034 Both ports request at cycle 5, port 0 completes cycle 7, port 1 completes cycle 12 -> freeze cycles 5-12, port 0 stays DONE cycles 8-12 with port_busy=10, release at 13.
REQ-035 id_ex_mem_read=1, id_ex_rd=3, if_id_rs=3, no mem_req -> one cycle pc_write=0, stage_write=1110, insert_bubble=1; same with id_ex_rd=0 -> no bubble.
REQ-036 Load-use and port 0 request same cycle -> full freeze, insert_bubble=0 until port 0 DONE; then one bubble cycle.
REQ-037 Reset asserted at cycle 3 of a port 1 WAIT -> next cycle all FSMs IDLE, stall_count=0, outputs all-run while reset held.
REQ-038 CNT_W=4, continuous stall for 20 cycles -> stall_count reaches 15 and holds.
